// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage pipeline.
// Owns stage valid bits, the MDU busy interlock and perf counters.
module pipe_hazard_ctrl #(
    parameter int RA_W    = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            icache_stall,
    input  logic            dcache_stall,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_is_jr,
    input  logic            id_redirect,
    input  logic            id_mdu_start,
    input  logic            id_use_mdu,
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] ex_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic            mem_memread,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [1:0]      fwd_j,
    output logic            v_id,
    output logic            v_ex,
    output logic            v_mem,
    output logic            v_wb,
    output logic            mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MW = (MDU_LAT < 1) ? 1 : $clog2(MDU_LAT + 1);

    logic [MW-1:0] mdu_cnt;
    logic          mstall;
    logic          lu;
    logic          jh;
    logic          mh;
    logic          hz;
    logic          ex_wr;
    logic          mem_ld;
    logic          mem_fw;
    logic          wb_fw;
    logic          mdu_load;

    assign mstall = icache_stall | dcache_stall;
    assign ex_wr  = v_ex & ex_regwrite & (ex_rd != '0);
    assign mem_ld = v_mem & mem_memread & (mem_rd != '0);
    assign mem_fw = v_mem & mem_regwrite & (mem_rd != '0);
    assign wb_fw  = v_wb & wb_regwrite & (wb_rd != '0);

    assign lu = v_ex & ex_memread & (ex_rd != '0)
              & ((id_use_rs & (ex_rd == id_rs))
               | (id_use_rt & (ex_rd == id_rt)));
    assign jh = v_id & id_is_jr
              & ((ex_wr & (ex_rd == id_rs))
               | (mem_ld & (mem_rd == id_rs)));
    assign mh = v_id & mdu_busy & (id_use_mdu | id_mdu_start);
    assign hz = lu | jh | mh;

    // Memory stall freezes everything; a hazard freezes only IF/ID.
    assign pc_en       = !mstall & !hz;
    assign ifid_en     = !mstall & !hz;
    assign idex_en     = !mstall;
    assign exmem_en    = !mstall;
    assign memwb_en    = !mstall;
    assign idex_bubble = hz & !mstall;
    assign ifid_flush  = id_redirect & v_id & !hz & !mstall;

    assign fwd_a = (mem_fw && mem_rd == ex_rs) ? 2'b10 :
                   (wb_fw && wb_rd == ex_rs)   ? 2'b01 : 2'b00;
    assign fwd_b = (mem_fw && mem_rd == ex_rt) ? 2'b10 :
                   (wb_fw && wb_rd == ex_rt)   ? 2'b01 : 2'b00;
    // A load in MEM has no data yet, so jr waits for it in WB.
    assign fwd_j = (mem_fw && !mem_memread && mem_rd == id_rs) ? 2'b10 :
                   (wb_fw && wb_rd == id_rs)                   ? 2'b01 :
                                                                 2'b00;

    assign mdu_busy = (mdu_cnt != '0);
    assign mdu_load = id_mdu_start & v_id & !hz & !mstall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else begin
            if (ifid_en)  v_id  <= !ifid_flush;
            if (idex_en)  v_ex  <= v_id & !idex_bubble;
            if (exmem_en) v_mem <= v_ex;
            if (memwb_en) v_wb  <= v_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt <= '0;
        end else if (mdu_load) begin
            mdu_cnt <= MW'(MDU_LAT);
        end else if (mdu_busy && !mstall) begin
            mdu_cnt <= mdu_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (idex_bubble && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenario bench for pipe_hazard_ctrl.
// Inputs change 1ns after posedge; outputs are checked mid-cycle.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       icache_stall, dcache_stall;
    logic [4:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt, id_is_jr, id_redirect;
    logic       id_mdu_start, id_use_mdu;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_regwrite, ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite, mem_memread;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_bubble;
    logic [1:0] fwd_a, fwd_b, fwd_j;
    logic       v_id, v_ex, v_mem, v_wb, mdu_busy;
    logic [15:0] stall_cnt, bubble_cnt, flush_cnt;

    int total = 0;
    int bad = 0;
    int e_stall = 0;
    int e_bub = 0;
    int e_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(5), .MDU_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_jr(id_is_jr), .id_redirect(id_redirect),
        .id_mdu_start(id_mdu_start), .id_use_mdu(id_use_mdu),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_j(fwd_j),
        .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
        .mdu_busy(mdu_busy),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt)
    );

    task automatic clear_in();
        icache_stall = 0; dcache_stall = 0;
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_jr = 0; id_redirect = 0;
        id_mdu_start = 0; id_use_mdu = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; mem_memread = 0;
        wb_rd = 0; wb_regwrite = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill();
        clear_in();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        #3;
        total++;
        if ({v_id, v_ex, v_mem, v_wb, mdu_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=00000",
                     {v_id, v_ex, v_mem, v_wb, mdu_busy});
        end
        total++;
        if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_bubble, fwd_a, fwd_b, fwd_j}
            !== 13'b11111_00_000000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=1111100000000",
                     {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_bubble, fwd_a, fwd_b, fwd_j});
        end
        total++;
        if ({stall_cnt, bubble_cnt, flush_cnt} !== 48'h0) begin
            bad++;
            $display("FAIL reset_cnt got=%h exp=0",
                     {stall_cnt, bubble_cnt, flush_cnt});
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 1; c <= 4; c++) begin
            logic [3:0] ev;
            ev = 4'b1111 << (4 - c);
            tick();
            total++;
            if ({v_id, v_ex, v_mem, v_wb} !== ev ||
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 5'h1f) begin
                bad++;
                $display("FAIL valid_rise c=%0d got=%b/%b exp=%b/11111", c,
                         {v_id, v_ex, v_mem, v_wb},
                         {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, ev);
            end
        end
    endtask

    task automatic test_load_use();
        clear_in();
        ex_rd = 8; ex_memread = 1; ex_regwrite = 1;
        id_rs = 8; id_use_rs = 1;
        #1;
        total++;
        if ({pc_en, ifid_en, idex_en, idex_bubble} !== 4'b0011) begin
            bad++;
            $display("FAIL lu_stall got=%b exp=0011",
                     {pc_en, ifid_en, idex_en, idex_bubble});
        end
        tick();
        e_stall++; e_bub++;
        ex_rd = 0; ex_memread = 0; ex_regwrite = 0;
        mem_rd = 8; mem_regwrite = 1; mem_memread = 1;
        #1;
        total++;
        if (pc_en !== 1'b1 || v_ex !== 1'b0 || bubble_cnt !== 16'(e_bub)) begin
            bad++;
            $display("FAIL lu_release got=%b/%b/%0d exp=1/0/%0d",
                     pc_en, v_ex, bubble_cnt, e_bub);
        end
        tick();
        ex_rs = 8;
        mem_rd = 0; mem_regwrite = 0; mem_memread = 0;
        wb_rd = 8; wb_regwrite = 1;
        #1;
        total++;
        if (fwd_a !== 2'b01 || v_mem !== 1'b0 || v_wb !== 1'b1) begin
            bad++;
            $display("FAIL lu_fwd_wb got=%b/%b/%b exp=01/0/1",
                     fwd_a, v_mem, v_wb);
        end
    endtask

    task automatic test_forward();
        refill();
        ex_rs = 5; ex_rt = 5;
        mem_rd = 5; mem_regwrite = 1;
        wb_rd = 5; wb_regwrite = 1;
        #1;
        total++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            bad++;
            $display("FAIL fwd_mem_wins got=%b/%b exp=10/10", fwd_a, fwd_b);
        end
        mem_rd = 6;
        #1;
        total++;
        if (fwd_a !== 2'b01) begin
            bad++;
            $display("FAIL fwd_wb got=%b exp=01", fwd_a);
        end
        ex_rs = 0; ex_rt = 7; mem_rd = 0; wb_rd = 0;
        #1;
        total++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            bad++;
            $display("FAIL fwd_r0 got=%b/%b exp=00/00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_jr();
        refill();
        id_is_jr = 1; id_rs = 31; id_use_rs = 1;
        mem_rd = 31; mem_memread = 1; mem_regwrite = 1;
        #1;
        total++;
        if (pc_en !== 1'b0 || idex_bubble !== 1'b1 || fwd_j !== 2'b00) begin
            bad++;
            $display("FAIL jr_ld_stall got=%b/%b/%b exp=0/1/00",
                     pc_en, idex_bubble, fwd_j);
        end
        tick();
        e_stall++; e_bub++;
        mem_rd = 0; mem_memread = 0; mem_regwrite = 0;
        wb_rd = 31; wb_regwrite = 1;
        #1;
        total++;
        if (pc_en !== 1'b1 || fwd_j !== 2'b01) begin
            bad++;
            $display("FAIL jr_fwd_wb got=%b/%b exp=1/01", pc_en, fwd_j);
        end
        wb_rd = 0; wb_regwrite = 0;
        mem_rd = 31; mem_regwrite = 1;
        #1;
        total++;
        if (pc_en !== 1'b1 || fwd_j !== 2'b10) begin
            bad++;
            $display("FAIL jr_fwd_mem got=%b/%b exp=1/10", pc_en, fwd_j);
        end
    endtask

    task automatic test_mdu();
        refill();
        id_mdu_start = 1;
        #1;
        total++;
        if (pc_en !== 1'b1 || mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL mdu_start got=%b/%b exp=1/0", pc_en, mdu_busy);
        end
        tick();
        id_mdu_start = 0; id_use_mdu = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (mdu_busy !== 1'b1 || pc_en !== 1'b0 || idex_bubble !== 1'b1) begin
                bad++;
                $display("FAIL mdu_hold i=%0d got=%b/%b/%b exp=1/0/1", i,
                         mdu_busy, pc_en, idex_bubble);
            end
            tick();
            e_stall++; e_bub++;
        end
        total++;
        if (mdu_busy !== 1'b0 || pc_en !== 1'b1 ||
            stall_cnt !== 16'(e_stall)) begin
            bad++;
            $display("FAIL mdu_done got=%b/%b/%0d exp=0/1/%0d",
                     mdu_busy, pc_en, stall_cnt, e_stall);
        end
    endtask

    task automatic test_mstall_combo();
        refill();
        ex_rd = 8; ex_memread = 1; ex_regwrite = 1;
        id_rs = 8; id_use_rs = 1;
        id_redirect = 1; dcache_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_bubble} !== 7'b0 ||
                {v_id, v_ex, v_mem, v_wb} !== 4'b1111) begin
                bad++;
                $display("FAIL mstall i=%0d got=%b/%b exp=0000000/1111", i,
                         {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_bubble}, {v_id, v_ex, v_mem, v_wb});
            end
            tick();
            e_stall++;
        end
        dcache_stall = 0;
        #1;
        total++;
        if (idex_bubble !== 1'b1 || ifid_flush !== 1'b0 || pc_en !== 1'b0) begin
            bad++;
            $display("FAIL combo_bubble got=%b/%b/%b exp=1/0/0",
                     idex_bubble, ifid_flush, pc_en);
        end
        tick();
        e_stall++; e_bub++;
        ex_rd = 0; ex_memread = 0; ex_regwrite = 0;
        mem_rd = 8; mem_memread = 1; mem_regwrite = 1;
        #1;
        total++;
        if (ifid_flush !== 1'b1 || pc_en !== 1'b1) begin
            bad++;
            $display("FAIL combo_flush got=%b/%b exp=1/1", ifid_flush, pc_en);
        end
        tick();
        e_flush++;
        total++;
        if (v_id !== 1'b0 || ifid_flush !== 1'b0 ||
            flush_cnt !== 16'(e_flush) || stall_cnt !== 16'(e_stall) ||
            bubble_cnt !== 16'(e_bub)) begin
            bad++;
            $display("FAIL combo_cnt got=%b/%b/%0d/%0d/%0d exp=0/0/%0d/%0d/%0d",
                     v_id, ifid_flush, flush_cnt, stall_cnt, bubble_cnt,
                     e_flush, e_stall, e_bub);
        end
    endtask

    task automatic test_saturate();
        refill();
        icache_stall = 1;
        repeat (65540) tick();
        total++;
        if (stall_cnt !== 16'hFFFF || bubble_cnt !== 16'(e_bub)) begin
            bad++;
            $display("FAIL saturate got=%h/%0d exp=ffff/%0d",
                     stall_cnt, bubble_cnt, e_bub);
        end
    endtask

    task automatic test_reset_mid();
        id_mdu_start = 1;
        icache_stall = 0;
        tick();
        #2;
        rst_n = 0;
        #1;
        total++;
        if ({v_id, v_ex, v_mem, v_wb, mdu_busy} !== 5'b0 ||
            {stall_cnt, bubble_cnt, flush_cnt} !== 48'h0) begin
            bad++;
            $display("FAIL reset_mid got=%b/%h exp=00000/0",
                     {v_id, v_ex, v_mem, v_wb, mdu_busy},
                     {stall_cnt, bubble_cnt, flush_cnt});
        end
        clear_in();
        @(negedge clk);
        rst_n = 1;
        tick();
        total++;
        if ({v_id, v_ex, v_mem, v_wb} !== 4'b1000) begin
            bad++;
            $display("FAIL restart got=%b exp=1000", {v_id, v_ex, v_mem, v_wb});
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_jr();
        test_mdu();
        test_mstall_combo();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised stall, flush and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Centralises all stage-enable, bubble-insertion and forwarding decisions in one block, replacing the ad-hoc glue in the core.
- Adds per-stage valid tracking, a multi-cycle MDU busy interlock, jr/jalr forwarding with stall, and saturating performance counters.

Parameters:
- RA_W, 5, register index width
- MDU_LAT, 4, MDU result latency in cycles (>=1)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- icache_stall  in  1  I-cache miss stall
- dcache_stall  in  1  D-cache miss stall
- id_rs, id_rt  in  RA_W  ID source regs
- id_use_rs, id_use_rt  in  1  ID instruction reads rs/rt
- id_is_jr  in  1  ID is jr/jalr (target from rs)
- id_redirect  in  1  ID resolved taken branch/jump
- id_mdu_start  in  1  ID is mult/div
- id_use_mdu  in  1  ID reads hi/lo (mfhi/mflo)
- ex_rs, ex_rt  in  RA_W  EX source regs
- ex_rd  in  RA_W  EX destination
- ex_regwrite, ex_memread  in  1  EX control
- mem_rd  in  RA_W  MEM destination
- mem_regwrite, mem_memread  in  1  MEM control
- wb_rd  in  RA_W  WB destination
- wb_regwrite  in  1  WB control
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage register enables
- ifid_flush  out  1  zero IF/ID instruction
- idex_bubble  out  1  load ID/EX with NOP controls
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_j  out  2  jr target select, same encoding
- v_id, v_ex, v_mem, v_wb  out  1  stage valid bits
- mdu_busy  out  1  MDU result pending
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W  perf counters

Behaviour:
- Reset (async): v_* = 0, MDU counter = 0, all counters = 0. Combinational outputs follow: all enables = 1, flush/bubble = 0, fwd_* = 00.
- mstall = icache_stall | dcache_stall. Highest priority: all five enables = 0, ifid_flush = 0, idex_bubble = 0, v_* hold, MDU counter holds.
- A hazard term is considered only when its stage valid bit is 1; regwrite to reg 0 never matches.
- lu (load-use): v_ex & ex_memread & ex_rd==rs/rt with the matching id_use_*.
- jh (jr hazard): v_id & id_is_jr & ((v_ex & ex_regwrite & ex_rd==id_rs) | (v_mem & mem_memread & mem_rd==id_rs)).
- mh (MDU hazard): v_id & mdu_busy & (id_use_mdu | id_mdu_start).
- hz = lu | jh | mh. When hz & !mstall: pc_en = ifid_en = 0; idex_en = 1, idex_bubble = 1; EX/MEM and MEM/WB advance. Exactly one bubble per stall cycle.
- ifid_flush = id_redirect & v_id & !hz & !mstall. A redirect that coincides with hz is deferred until hz clears.
- Valid update on stage enable:
  - v_id <= !ifid_flush
  - v_ex <= v_id & !idex_bubble
  - v_mem <= v_ex
  - v_wb <= v_mem
- fwd_a: 10 if v_mem & mem_regwrite & mem_rd!=0 & mem_rd==ex_rs; else 01 if v_wb & wb_regwrite & wb_rd!=0 & wb_rd==ex_rs; else 00. EX/MEM wins over MEM/WB.
- fwd_b: same rule on ex_rt.
- fwd_j: same rule on id_rs, requiring !mem_memread for the 10 case.
- MDU counter:
  - Loads MDU_LAT when id_mdu_start & v_id & !hz & !mstall.
  - Otherwise decrements while >0 and !mstall.
  - mdu_busy = (counter != 0).
- Counters, saturating at 2^CNT_W-1:
  - stall_cnt +1 each cycle with pc_en = 0.
  - bubble_cnt +1 each cycle with idex_bubble = 1.
  - flush_cnt +1 each cycle with ifid_flush = 1.
- Reset asserted mid-operation clears all state immediately; the pipeline restarts with all stages invalid.

Test Plan:
- Reset release, no hazards, 4 cycles -> all enables 1; valid bits rise in order: v_id at cycle 1, v_wb at cycle 4.
- lw $8 in EX, ID add reads $8 via rs -> 1 cycle pc_en = 0 and idex_bubble = 1; next cycle fwd_a = 01 (from WB) once the load has advanced; bubble_cnt = 1.
- EX add writes $5 with MEM also writing $5, EX operand rs=$5 -> fwd_a = 10; same case with rd=$0 -> fwd_a = 00.
- jr $31 in ID with lw $31 in MEM -> stall 1 cycle, then fwd_j = 01; jr with addu $31 in MEM -> fwd_j = 10, no stall.
- mult then mfhi, MDU_LAT=4 -> mfhi held 4 cycles with mdu_busy = 1; stall_cnt = 4.
- dcache_stall for 3 cycles during load-use plus redirect -> all enables 0 for 3 cycles; then bubble, then flush; flush_cnt = 1; counter saturates at 0xFFFF under forced long stall.
